// File: rtl/fixed2_mac_seq_if.sv
// Operand feed, 8x2 MAC-cell drive and result handshake bundle for fixed2_mac_seq.
// The slave modport is the sequencer; the master modport is the surrounding datapath.
interface fixed2_mac_seq_if #(
  parameter int unsigned COL_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_act;
  logic [7:0]           in_wgt;
  logic                 in_s_act;
  logic                 in_s_wgt;
  logic [1:0]           in_prec;
  logic [7:0]           cell_in;
  logic [1:0]           cell_weight;
  logic                 cell_s_in;
  logic                 cell_s_weight;
  logic [COL_WIDTH-1:0] cell_psum_in;
  logic [COL_WIDTH-1:0] cell_psum_fwd;
  logic                 out_valid;
  logic                 out_ready;
  logic [COL_WIDTH-1:0] out_psum;
  logic                 busy;

  modport slave (
    input  in_valid, in_act, in_wgt, in_s_act, in_s_wgt, in_prec,
    input  cell_psum_fwd, out_ready,
    output in_ready, cell_in, cell_weight, cell_s_in, cell_s_weight, cell_psum_in,
    output out_valid, out_psum, busy
  );

  modport master (
    output in_valid, in_act, in_wgt, in_s_act, in_s_wgt, in_prec,
    output cell_psum_fwd, out_ready,
    input  in_ready, cell_in, cell_weight, cell_s_in, cell_s_weight, cell_psum_in,
    input  out_valid, out_psum, busy
  );
endinterface

// File: rtl/fixed2_mac_seq.sv
// Sequences one 8-bit x 2/4/8-bit product through an external 8x2 MAC cell,
// feeding weight slices MSB-first and accumulating in Horner form.
module fixed2_mac_seq #(
  parameter int unsigned COL_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fixed2_mac_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [COL_WIDTH-1:0] acc;
  logic [1:0]           k;
  logic [1:0]           last_k;
  logic [7:0]           act_l;
  logic [7:0]           wgt_l;
  logic                 s_act_l;
  logic                 s_wgt_l;
  logic [1:0]           prec_top;
  logic                 running;
  logic [1:0]           slice;

  // Index of the most significant weight slice: n-1 for n = 1, 2, 4.
  always_comb begin
    prec_top = 2'd3;
    case (bus.in_prec)
      2'b00:   prec_top = 2'd0;
      2'b01:   prec_top = 2'd1;
      default: prec_top = 2'd3;
    endcase
  end

  assign running = (state == RUN);
  assign slice   = wgt_l[{k, 1'b0} +: 2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      k       <= 2'd0;
      last_k  <= 2'd0;
      act_l   <= 8'd0;
      wgt_l   <= 8'd0;
      s_act_l <= 1'b0;
      s_wgt_l <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            act_l   <= bus.in_act;
            wgt_l   <= bus.in_wgt;
            s_act_l <= bus.in_s_act;
            s_wgt_l <= bus.in_s_wgt;
            last_k  <= prec_top;
            k       <= prec_top;
            acc     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= bus.cell_psum_fwd;
          if (k == 2'd0) begin
            state <= DONE;
          end else begin
            k <= k - 2'd1;
          end
        end
        DONE: begin
          // acc is held here and after the handshake until the next accept
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_psum  = acc;

  // Cell drive is a decode of registered state; zero outside RUN.
  assign bus.cell_in       = running ? act_l : 8'd0;
  assign bus.cell_weight   = running ? slice : 2'd0;
  assign bus.cell_s_in     = running && s_act_l;
  assign bus.cell_s_weight = running && s_wgt_l && (k == last_k);
  assign bus.cell_psum_in  = running ? {acc[COL_WIDTH-3:0], 2'b00} : '0;

endmodule

// File: tb/tb_fixed2_mac_seq.sv
// Directed-vector bench for fixed2_mac_seq with a behavioural 8x2 MAC cell.
module tb_fixed2_mac_seq;

  localparam int unsigned COL_WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  logic last_sw_seen;
  logic [15:0] last_psum2;

  fixed2_mac_seq_if #(.COL_WIDTH(COL_WIDTH)) bus ();

  fixed2_mac_seq #(.COL_WIDTH(COL_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cell: signed/unsigned 8x2 product added to psum_in.
  logic signed [9:0]  cell_a;
  logic signed [2:0]  cell_w;
  logic signed [12:0] cell_p;
  always_comb begin
    cell_a = bus.cell_s_in ? {{2{bus.cell_in[7]}}, bus.cell_in} : {2'b00, bus.cell_in};
    cell_w = bus.cell_s_weight ? {bus.cell_weight[1], bus.cell_weight} : {1'b0, bus.cell_weight};
    cell_p = cell_a * cell_w;
    bus.cell_psum_fwd = bus.cell_psum_in + {{3{cell_p[12]}}, cell_p};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, wait for result (bounded), check, handshake.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] w,
                       input logic sa, input logic sw, input logic [1:0] p,
                       input logic [15:0] exp, input int lat);
    int cyc;
    logic sw_seen;
    logic [15:0] psum2;
    check($sformatf("%s_rdy", tag), 32'(bus.in_ready), 32'd1);
    bus.in_act   = a;
    bus.in_wgt   = w;
    bus.in_s_act = sa;
    bus.in_s_wgt = sw;
    bus.in_prec  = p;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    sw_seen = 1'b0;
    psum2 = 16'd0;
    while (!bus.out_valid && cyc < 20) begin
      if (bus.cell_s_weight) sw_seen = 1'b1;
      if (cyc == 1) psum2 = bus.cell_psum_in;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_lat", tag), 32'(cyc), 32'(lat));
    check($sformatf("%s_psum", tag), 32'(bus.out_psum), 32'(exp));
    last_sw_seen = sw_seen;
    last_psum2   = psum2;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("%s_idle", tag), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int rdy_idx[$];
    int val_idx;
    logic [15:0] val_psum;

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_act = 8'd0;
    bus.in_wgt = 8'd0;
    bus.in_s_act = 1'b0;
    bus.in_s_wgt = 1'b0;
    bus.in_prec = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_psum", 32'(bus.out_psum), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cell", {bus.cell_in, bus.cell_weight, bus.cell_s_in, bus.cell_s_weight, 4'd0, bus.cell_psum_in[11:0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit unsigned: 200 x 150 = 30000
    do_op("u8", 8'd200, 8'd150, 1'b0, 1'b0, 2'b10, 16'h7530, 4);
    check("u8_sw", 32'(last_sw_seen), 32'd0);

    // 8-bit signed -128 x -128 = 16384, prec 10 and 11
    do_op("s8", 8'h80, 8'h80, 1'b1, 1'b1, 2'b10, 16'h4000, 4);
    check("s8_sw", 32'(last_sw_seen), 32'd1);
    do_op("s8p11", 8'h80, 8'h80, 1'b1, 1'b1, 2'b11, 16'h4000, 4);

    // 4-bit: -3 x -6 = 18, upper weight nibble ignored; step-2 psum_in = 24
    do_op("s4", 8'hFD, 8'hFA, 1'b1, 1'b1, 2'b01, 16'h0012, 2);
    check("s4_psum2", 32'(last_psum2), 32'h18);

    // 2-bit back-to-back: 255 x -1 with in_valid and out_ready held high
    bus.in_act = 8'd255;
    bus.in_wgt = 8'h03;
    bus.in_s_act = 1'b0;
    bus.in_s_wgt = 1'b1;
    bus.in_prec = 2'b00;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    val_idx = -1;
    val_psum = 16'd0;
    for (int t = 0; t < 10; t++) begin
      if (bus.in_ready) rdy_idx.push_back(t);
      if (bus.out_valid && val_idx < 0) begin
        val_idx = t;
        val_psum = bus.out_psum;
      end
      if (t < 9) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_nrdy", 32'(rdy_idx.size()), 32'd4);
    check("b2b_period", (rdy_idx.size() >= 2) ? 32'(rdy_idx[1] - rdy_idx[0]) : 32'hFFFF_FFFF, 32'd3);
    check("b2b_lat", (rdy_idx.size() >= 1) ? 32'(val_idx - rdy_idx[0]) : 32'hFFFF_FFFF, 32'd2);
    check("b2b_psum", 32'(val_psum), 32'hFF01);
    @(posedge clk); #1;

    // Backpressure: 10 x 3 = 30 held for 5 cycles, pending 7 x 2 = 14
    bus.in_act = 8'd10;
    bus.in_wgt = 8'd3;
    bus.in_s_act = 1'b0;
    bus.in_s_wgt = 1'b0;
    bus.in_prec = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_act = 8'd7;
    bus.in_wgt = 8'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_psum%0d", i), 32'(bus.out_psum), 32'd30);
      check($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
    check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_acc_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_psum", 32'(bus.out_psum), 32'd14);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset during the second RUN step of an 8-bit op
    bus.in_act = 8'h80;
    bus.in_wgt = 8'h80;
    bus.in_s_act = 1'b1;
    bus.in_s_wgt = 1'b1;
    bus.in_prec = 2'b10;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr_run_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_rdy", 32'(bus.in_ready), 32'd0);
    check("mr_cell", {bus.cell_in, bus.cell_weight, bus.cell_s_in, bus.cell_s_weight, 4'd0, bus.cell_psum_in[11:0]}, 32'd0);
    check("mr_cell_psum", 32'(bus.cell_psum_in), 32'd0);
    check("mr_psum", 32'(bus.out_psum), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 8'd200, 8'd150, 1'b0, 1'b0, 2'b10, 16'h7530, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fixed2_mac_seq.md
# fixed2_mac_seq

Sequencer that computes one 8-bit activation × 2/4/8-bit weight product by driving an external 2-bit fixed-point multiply-accumulate cell over 1, 2 or 4 cycles. Weight slices are fed MSB-first, and the partial sum is shifted and accumulated (Horner form). The block sits between the operand feed and a single 8×2 cell. It owns the cell's operand, sign and psum inputs, and returns the finished psum over a valid/ready handshake.

## Interface
- COL_WIDTH, 16, width of the psum path and result. The full 8×8 product fits in two's complement or unsigned at 16 bits.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- in_act  in  8  activation
- in_wgt  in  8  weight; only the low 2·n bits are used
- in_s_act  in  1  activation is signed
- in_s_wgt  in  1  weight is signed
- in_prec  in  2  weight precision: 00 = 2-bit (n=1), 01 = 4-bit (n=2), 10 or 11 = 8-bit (n=4)
- cell_in  out  8  activation to the cell
- cell_weight  out  2  weight slice to the cell
- cell_s_in  out  1  cell activation sign flag
- cell_s_weight  out  1  cell weight-slice sign flag
- cell_psum_in  out  COL_WIDTH  psum into the cell
- cell_psum_fwd  in  COL_WIDTH  cell result, combinational: cell_in·cell_weight + cell_psum_in, mod 2^COL_WIDTH
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_psum  out  COL_WIDTH  result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE, in_valid & in_ready:
  - latch act, wgt, s_act, s_wgt and n.
  - k ← n−1, acc ← 0.
  - go to RUN.
- RUN, each cycle:
  - cell_in = act_l; cell_weight = wgt_l[2k+1:2k].
  - cell_s_in = s_act_l; cell_s_weight = s_wgt_l & (k == n−1). Only the top slice is signed.
  - cell_psum_in = {acc[COL_WIDTH-3:0], 2'b00}.
  - acc ← cell_psum_fwd.
  - if k == 0, go to DONE; else k ← k−1.
- DONE:
  - out_psum = acc.
  - on out_ready, go to IDLE. acc is held until the next accept.
- Outside RUN: cell_in, cell_weight, cell_psum_in, cell_s_in and cell_s_weight are driven to 0.
- Arithmetic: all results are mod 2^COL_WIDTH. A 16-bit result is exact for every sign combination. A narrower COL_WIDTH wraps silently.
- Bits of in_wgt above 2n−1 are ignored.
- in_prec = 11 behaves exactly as 10.
- Operand inputs are sampled only at the accept edge. Changes on them during RUN or DONE have no effect.
- Reset (rst_n low at an edge, from any state, including mid-RUN): state ← IDLE, acc ← 0, k ← 0, all latched operands ← 0.
- While rst_n is low, in_ready = 0.

## Timing
- Reset values: in_ready=0 while in reset and 1 after; out_valid=0; out_psum=0; busy=0; all cell_* outputs = 0.
- Accept at edge E0. RUN occupies the cycles after edges E0 … E0+n−1.
- out_valid rises after edge E0+n, i.e. latency n cycles: 1, 2 or 4.
- out_psum is stable while out_valid=1 and out_ready=0, for any duration.
- Result handshake at edge E1 → IDLE. The next accept can happen no earlier than E1+1.
- Minimum period, with out_ready held high: n+2 cycles.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
- The cell path is combinational within the cycle: cell_* outputs → cell_psum_fwd → acc register.

## Test plan
- prec=10, act=200 unsigned, wgt=150 unsigned → out_psum=0x7530 (30000); out_valid exactly 4 cycles after accept; cell_s_weight=0 on all steps.
- prec=10, act=0x80 signed, wgt=0x80 signed → 0x4000 (16384). Same operands with prec=11 → identical result and latency.
- prec=00, act=255 unsigned, wgt=0x03 signed (−1) → 0xFF01 (−255) after 1 cycle; period 3 cycles with out_ready=1 and in_valid held high.
- prec=01, act=0xFD signed (−3), wgt=0xFA signed (low nibble −6, upper nibble ignored) → 0x0012 (18); cell_psum_in=0x0018 on the second step.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_psum constant, in_ready=0, a concurrent in_valid is not accepted; release → IDLE next cycle, then the pending request is accepted.
- rst_n low for 1 cycle during the 2nd RUN step of an 8-bit op → next cycle busy=0, out_valid=0, cell_* outputs = 0; a following op (200×150 unsigned) returns 30000.
